// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the four-requester round-robin mux arbiter.
package rr_arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bus of the round-robin mux arbiter.
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    import rr_arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
    logic [NREQ-1:0]  gnt;
    logic [SELW-1:0]  select;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    // Requester side: drives requests and data, observes the arbitration result.
    modport master (
        output req, din0, din1, din2, din3,
        input  gnt, select, dout, dout_valid
    );

    // Arbiter side.
    modport slave (
        input  req, din0, din1, din2, din3,
        output gnt, select, dout, dout_valid
    );

endinterface

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational round-robin picker: first set bit of req searching upward from last+1.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] last,
    output logic            any,
    output logic [SELW-1:0] idx
);

    always_comb begin
        logic [SELW-1:0] w_cand;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        any    = |req;
        idx    = '0;
        w_cand = '0;
        // Walk from the lowest priority (last+4 == last) up to last+1, so the
        // nearest requester after last is written last and wins.
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = last + SELW'(k);
            if (req[w_cand]) idx = w_cand;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with burst limit steering one of four inputs onto dout.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input logic              clk,
    input logic              rst_n,
    rr_mux_arbiter_if.slave  bus
);

    localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [SELW-1:0]   r_select;
    logic [SELW-1:0]   r_last;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [NREQ-1:0]   w_others;
    logic [NREQ-1:0]   w_pick_req;
    logic [SELW-1:0]   w_pick_last;
    logic              w_any;
    logic [SELW-1:0]   w_idx;
    logic              w_owner_req;
    logic [WIDTH-1:0]  w_dout;

    // While granted, the owner is masked out so the pick is always the next one after it.
    assign w_others    = bus.req & ~onehot(r_select);
    assign w_pick_req  = (r_state == GRANT) ? w_others : bus.req;
    assign w_pick_last = (r_state == GRANT) ? r_select : r_last;
    assign w_owner_req = bus.req[r_select];

    rr_pick4 u_pick (
        .req  (w_pick_req),
        .last (w_pick_last),
        .any  (w_any),
        .idx  (w_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_select   <= '0;
            r_last     <= 2'b11;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= GRANT;
                        r_gnt      <= onehot(w_idx);
                        r_select   <= w_idx;
                        r_last     <= w_idx;
                        r_hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!w_owner_req) begin
                        r_hold_cnt <= '0;
                        if (w_any) begin
                            r_gnt    <= onehot(w_idx);
                            r_select <= w_idx;
                            r_last   <= w_idx;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                        end
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end else begin
                        // Burst limit reached: hand over if anyone else waits.
                        r_hold_cnt <= '0;
                        if (w_any) begin
                            r_gnt    <= onehot(w_idx);
                            r_select <= w_idx;
                            r_last   <= w_idx;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        case (r_select)
            2'd0:    w_dout = bus.din0;
            2'd1:    w_dout = bus.din1;
            2'd2:    w_dout = bus.din2;
            default: w_dout = bus.din3;
        endcase
    end

    assign bus.gnt        = r_gnt;
    assign bus.select     = r_select;
    assign bus.dout       = w_dout;
    assign bus.dout_valid = |r_gnt;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_rr_mux_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    rr_mux_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state: owner index (-1 = idle), cycles already held, last owner, select value.
    int m_owner;
    int m_cnt;
    int m_last;
    int m_sel;
    logic [WIDTH-1:0] din_a [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                           input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        din_a[0] = d0; din_a[1] = d1; din_a[2] = d2; din_a[3] = d3;
        bus.din0 = d0; bus.din1 = d1; bus.din2 = d2; bus.din3 = d3;
    endtask

    function automatic int pick_after(input logic [3:0] r, input int after);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (after + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r);
        int p;
        logic [3:0] others;
        if (m_owner < 0) begin
            p = pick_after(r, m_last);
            if (p >= 0) begin
                m_owner = p; m_sel = p; m_last = p; m_cnt = 0;
            end
        end else begin
            others          = r;
            others[m_owner] = 1'b0;
            p               = pick_after(others, m_owner);
            if (!r[m_owner]) begin
                m_cnt = 0;
                if (p >= 0) begin
                    m_owner = p; m_sel = p; m_last = p;
                end else begin
                    m_owner = -1;
                end
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                if (p >= 0) begin
                    m_owner = p; m_sel = p; m_last = p;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [3:0] exp_g;
        exp_g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check({tag, ".gnt"},    32'(bus.gnt),        32'(exp_g));
        check({tag, ".select"}, 32'(bus.select),     32'(m_sel));
        check({tag, ".dout"},   32'(bus.dout),       32'(din_a[m_sel]));
        check({tag, ".valid"},  32'(bus.dout_valid), 32'(m_owner >= 0));
    endtask

    // One clock edge: advance the model with the sampled requests, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge(bus.req);
        #1;
        compare_model(tag);
    endtask

    // Asserts reset off-edge, checks the asynchronous clear, releases after two edges.
    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        m_owner = -1; m_cnt = 0; m_last = 3; m_sel = 0;
        #1;
        check({tag, ".rst_gnt"},    32'(bus.gnt),        32'h0);
        check({tag, ".rst_select"}, 32'(bus.select),     32'h0);
        check({tag, ".rst_valid"},  32'(bus.dout_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_model({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        set_din(8'hA0, 8'hB1, 8'hC2, 8'hD3);

        // Reset with all requesting, then rotation and data steering.
        do_reset("t1");
        for (int e = 1; e <= 29; e++) begin
            int own;
            own = ((e - 1) / 4) % 4;
            step("t2");
            check("t2.rot_gnt",  32'(bus.gnt),  32'(1 << own));
            check("t5.rot_dout", 32'(bus.dout), 32'(din_a[own]));
        end
        check("t6.pre_gnt", 32'(bus.gnt), 32'h8);

        // Mid-grant reset: first pick after release is requester 0 again.
        bus.req = 4'b1001;
        do_reset("t6");
        step("t6");
        check("t6.first_gnt", 32'(bus.gnt), 32'h1);

        // Early release by owner 1: handover to 3 on the same edge.
        bus.req = 4'b0010;
        do_reset("t3");
        step("t3");
        check("t3.own1_a", 32'(bus.gnt), 32'h2);
        bus.req = 4'b1010;
        step("t3");
        check("t3.own1_b", 32'(bus.gnt), 32'h2);
        bus.req = 4'b1000;
        step("t3");
        check("t3.switch", 32'(bus.gnt), 32'h8);

        // Lone requester keeps the grant past the burst limit, then idles.
        bus.req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            step("t4");
            check("t4.lone_gnt", 32'(bus.gnt), 32'h4);
        end
        bus.req = 4'b0000;
        step("t4");
        check("t4.idle_gnt",   32'(bus.gnt),        32'h0);
        check("t4.idle_valid", 32'(bus.dout_valid), 32'h0);
        check("t4.idle_sel",   32'(bus.select),     32'h2);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            bus.req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                set_din(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 99) == 0) do_reset("rnd");
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
